// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    // Access sequencing: wait for a request, run it on the memory, report it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Port that owns the access currently in flight.
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch port and the data port onto one unified memory.
// The data port has priority, but after STARVE_LIMIT consecutive data grants
// that the fetch port lost, the fetch port wins once.
// A memory access that gets no m_ack for TIMEOUT cycles is aborted. The
// requester then sees a done pulse with zero read data, and bus_err is set.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_f,
    output logic              stall_m,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              bus_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

    state_t            state, state_next;
    gnt_t              gnt, gnt_sel;
    logic              take_grant, acked, timed_out;
    logic [SW-1:0]     starve_cnt;
    logic [WW-1:0]     wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              we_q;

    // State register. Reset acts immediately, so a reset in MEM drops m_req at once.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next state, grant choice, and completion and timeout events.
    always_comb begin
        // NOTE: defaults first, so no path leaves a signal unassigned (no latch).
        state_next = state;
        gnt_sel    = GNT_D;
        take_grant = 1'b0;
        acked      = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    take_grant = 1'b1;
                    state_next = MEM;
                    if (i_req && (!d_req || starve_cnt == STARVE_MAX)) gnt_sel = GNT_I;
                end
            end
            MEM: begin
                if (m_ack) begin
                    acked      = 1'b1;
                    state_next = RESP;
                end else if (wait_cnt == WAIT_LAST) begin
                    timed_out  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the granted access, track fetch starvation, time the memory and capture read data.
    // NOTE: these few address/data registers are reset too, so outputs are defined from reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt        <= GNT_D;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            bus_err    <= 1'b0;
        end else begin
            if (take_grant) begin
                gnt      <= gnt_sel;
                wait_cnt <= '0;
                if (gnt_sel == GNT_I) begin
                    addr_q     <= i_addr;
                    wdata_q    <= '0;
                    we_q       <= 1'b0;
                    starve_cnt <= '0;
                end else begin
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                    we_q    <= d_we;
                    if (i_req && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + SW'(1);
                end
            end
            if (state == MEM && !m_ack) wait_cnt <= wait_cnt + WW'(1);
            if (acked)     rdata_q <= we_q ? '0 : m_rdata;
            if (timed_out) begin
                rdata_q <= '0;
                bus_err <= 1'b1;
            end
        end
    end

    // Memory-side and requester-side outputs, all decoded from registered state.
    always_comb begin
        m_req   = (state == MEM);
        m_we    = we_q && (state == MEM);
        m_addr  = addr_q;
        m_wdata = wdata_q;
        i_done  = (state == RESP) && (gnt == GNT_I);
        d_done  = (state == RESP) && (gnt == GNT_D);
        i_rdata = i_done ? rdata_q : '0;
        d_rdata = d_done ? rdata_q : '0;
        stall_f = i_req && !i_done;
        stall_m = d_req && !d_done;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter. The stimulus pushes each expected
// completion into a queue. A negedge monitor pops one entry on every done
// pulse and checks the port, the read data, the memory-side address, we and
// wdata, and the number of MEM cycles the access took.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_done, d_done, stall_f, stall_m, m_req, m_we, m_ack, bus_err;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          mem_cyc;
    } exp_t;

    exp_t sb[$];
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;

    // Memory responder controls: ack in MEM cycle number ack_delay (0-based), -1 = never.
    int   ack_delay = 0;
    logic stray_ack = 1'b0;
    int   mem_cyc   = 0;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .stall_f(stall_f), .stall_m(stall_m),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: 0x10 holds an addi instruction, everything else is derived from the address.
    function automatic logic [31:0] mem_value(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0050_0113;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Unified memory model, driven 1 time unit after each rising edge.
    initial begin
        m_ack   = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (m_req) begin
                m_ack   = (ack_delay >= 0) && (mem_cyc == ack_delay);
                m_rdata = m_ack ? mem_value(m_addr) : 32'hBAD0_BAD0;
                mem_cyc++;
            end else begin
                mem_cyc = 0;
                m_ack   = stray_ack;
                m_rdata = stray_ack ? 32'h1234_5678 : '0;
            end
        end
    end

    // Monitor: checks that the memory side is stable during MEM and scores every done pulse.
    initial begin
        logic [31:0] cap_addr, cap_wdata;
        logic        cap_we;
        bit          in_mem;
        int          mem_len;
        exp_t        e;
        in_mem  = 0;
        mem_len = 0;
        cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
        forever begin
            @(negedge clk);
            if (m_req) begin
                if (!in_mem) begin
                    cap_addr  = m_addr;
                    cap_we    = m_we;
                    cap_wdata = m_wdata;
                    in_mem    = 1;
                    mem_len   = 1;
                end else begin
                    mem_len++;
                    check("m_addr_stable", m_addr, cap_addr);
                    check("m_we_stable", m_we, cap_we);
                    check("m_wdata_stable", m_wdata, cap_wdata);
                end
            end else begin
                in_mem = 0;
            end
            if (i_done || d_done) begin
                check("single_done", i_done & d_done, 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got i_done=%b d_done=%b expected none at %0t",
                             i_done, d_done, $time);
                end else begin
                    e = sb.pop_front();
                    check("done_port", d_done, e.is_d);
                    check("done_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
                    check("mem_addr", cap_addr, e.addr);
                    check("mem_we", cap_we, e.we);
                    if (e.we) check("mem_wdata", cap_wdata, e.wdata);
                    check("mem_cycles", mem_len, e.mem_cyc);
                end
                done_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Wait until n more done pulses are seen, then return 1 time unit after the edge that leaves RESP.
    task automatic wait_dones(input int n);
        int target;
        int c;
        target = done_cnt + n;
        c = 0;
        while (done_cnt < target && c < 200) begin
            @(posedge clk);
            c++;
        end
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL done_wait: got %0d dones expected %0d", done_cnt, target);
        end
        #1;
    endtask

    function automatic exp_t mk(input logic is_d, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input int cyc);
        exp_t e;
        e.is_d = is_d; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.mem_cyc = cyc;
        return e;
    endfunction

    // A single access on one port. It is called 1 time unit after a rising edge, with the DUT in IDLE.
    task automatic access(input logic is_d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int dly);
        ack_delay = dly;
        sb.push_back(mk(is_d, we, addr, wdata, rdata, (dly < 0) ? 16 : dly + 1));
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        wait_dones(1);
        if (is_d) d_req = 1'b0;
        else      i_req = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_m_req", m_req, 0);
        check("rst_m_we", m_we, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_done", {i_done, d_done}, 0);
        check("rst_bus_err", bus_err, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Minimum-latency fetch: cycle 0 IDLE, cycle 1 MEM with ack, cycle 2 done
        ack_delay = 0;
        sb.push_back(mk(1'b0, 1'b0, 32'h10, 32'h0, 32'h0050_0113, 1));
        i_req = 1'b1; i_addr = 32'h0000_0010;
        @(negedge clk);
        check("c0_stall_f", stall_f, 1);
        check("c0_m_req", m_req, 0);
        @(negedge clk);
        check("c1_m_req", m_req, 1);
        check("c1_m_addr", m_addr, 32'h10);
        check("c1_m_we", m_we, 0);
        check("c1_stall_f", stall_f, 1);
        @(negedge clk);
        check("c2_i_done", i_done, 1);
        check("c2_stall_f", stall_f, 0);
        @(posedge clk); #1;
        i_req = 1'b0;

        // Write with the ack in the third MEM cycle: write done carries zero data
        access(1'b1, 1'b1, 32'h64, 32'hDEAD_BEEF, 32'h0, 2);
        access(1'b1, 1'b0, 32'h80, 32'h0, 32'h0080_FF7F, 1);

        // Simultaneous requests: data first, then fetch
        ack_delay = 0;
        sb.push_back(mk(1'b1, 1'b0, 32'h200, 32'h0, 32'h0200_FDFF, 1));
        sb.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0, 32'h0100_FEFF, 1));
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = '0;
        wait_dones(1);
        d_req = 1'b0;
        wait_dones(1);
        i_req = 1'b0;

        // A stray m_ack while IDLE must be ignored
        stray_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stray_m_req", m_req, 0);
        end
        @(posedge clk); #1;
        stray_ack = 1'b0;

        // Starvation: data held continuously, fetch wins after 4 data grants, and the count restarts
        ack_delay = 0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) sb.push_back(mk(1'b1, 1'b0, 32'h200, 32'h0, 32'h0200_FDFF, 1));
            sb.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0, 32'h0100_FEFF, 1));
        end
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        wait_dones(10);
        i_req = 1'b0; d_req = 1'b0;

        // Timeout: no ack for 16 MEM cycles, then bus_err stays set through good accesses
        check("pre_timeout_bus_err", bus_err, 0);
        access(1'b1, 1'b0, 32'h300, 32'h0, 32'h0, -1);
        check("timeout_bus_err", bus_err, 1);
        access(1'b0, 1'b0, 32'h10, 32'h0, 32'h0050_0113, 0);
        check("sticky_bus_err", bus_err, 1);

        // Reset in the second MEM cycle: m_req drops at once and no done is pulsed
        ack_delay = -1;
        i_req = 1'b1; i_addr = 32'h40;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_m_req", m_req, 0);
        check("async_rst_done", {i_done, d_done}, 0);
        check("async_rst_bus_err", bus_err, 0);
        i_req = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 1'b0, 32'h40, 32'h0, 32'h0040_FFBF, 0);
        check("post_rst_bus_err", bus_err, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
